// File: rtl/btn_pkg.sv
// Shared constants for the front-panel button conditioner: default debounce/hold timing,
// button indices and counter-width helpers.
package btn_pkg;

    // Default timing in timebase ticks (1 kHz strobe: 20 ms debounce, 1 s long press, 200 ms repeat)
    localparam int unsigned BTN_STABLE_TICKS = 20;
    localparam int unsigned BTN_LONG_TICKS   = 1000;
    localparam int unsigned BTN_REPEAT_TICKS = 200;

    // Channel assignment on the clock's front panel
    localparam int unsigned BTN_MODE = 0;
    localparam int unsigned BTN_SET  = 1;
    localparam int unsigned BTN_ADJ  = 2;

    function automatic int unsigned btn_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold the values 0..n
    function automatic int unsigned btn_cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/button_channel.sv
// One debounced button: two-flop synchroniser, tick-qualified stable counter, press/release
// pulses and hold counter producing long-press and auto-repeat pulses.
module button_channel
    import btn_pkg::*;
#(
    parameter bit          ACTIVE_LOW   = 1'b1,
    parameter int unsigned STABLE_TICKS = BTN_STABLE_TICKS,
    parameter int unsigned LONG_TICKS   = BTN_LONG_TICKS,
    parameter int unsigned REPEAT_TICKS = BTN_REPEAT_TICKS
) (
    input  logic clk,
    input  logic rstn,
    input  logic tick,
    input  logic pin,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic long_press,
    output logic repeat_pulse
);

    localparam int unsigned SW = btn_cnt_width(STABLE_TICKS);
    localparam int unsigned HW = btn_cnt_width(btn_max(LONG_TICKS, REPEAT_TICKS));

    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_TICKS - 1);
    localparam logic [HW-1:0] LONG_CNT  = HW'(LONG_TICKS);
    localparam logic [HW-1:0] REP_CNT   = HW'(REPEAT_TICKS);
    localparam bit            REP_EN    = (REPEAT_TICKS != 0);

    if (STABLE_TICKS == 0) begin : g_bad_stable
        $error("button_channel: STABLE_TICKS must be at least 1");
    end
    if (LONG_TICKS == 0) begin : g_bad_long
        $error("button_channel: LONG_TICKS must be at least 1");
    end

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          act;
    logic [SW-1:0] stab_q, stab_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [HW-1:0] hold_inc;
    logic          holding;
    logic          long_done_q, long_done_d;
    logic          long_q, long_d;
    logic          rep_q, rep_d;

    always_comb begin
        sync1_d = pin;
        sync2_d = sync1_q;
    end

    // act is 1 while the button is pressed, independent of pin polarity
    assign act = sync2_q ^ ACTIVE_LOW;

    // Any sample that agrees with the debounced level restarts qualification
    always_comb begin
        stab_d  = stab_q;
        level_d = level_q;
        if (act == level_q) begin
            stab_d = '0;
        end else if (tick) begin
            if (stab_q == STAB_LAST) begin
                level_d = ~level_q;
                stab_d  = '0;
            end else begin
                stab_d = stab_q + 1'b1;
            end
        end
    end

    always_comb begin
        press_d   = level_d & ~level_q;
        release_d = ~level_d & level_q;
    end

    // Hold timing only runs while the level is high now and stays high this cycle, so a
    // release can never coincide with a long-press or repeat pulse.
    assign holding  = level_q & level_d;
    assign hold_inc = hold_q + 1'b1;

    always_comb begin
        hold_d      = hold_q;
        long_done_d = long_done_q;
        long_d      = 1'b0;
        rep_d       = 1'b0;
        if (!holding) begin
            hold_d      = '0;
            long_done_d = 1'b0;
        end else if (tick) begin
            if (!long_done_q) begin
                if (hold_inc == LONG_CNT) begin
                    long_d      = 1'b1;
                    long_done_d = 1'b1;
                    hold_d      = '0;
                end else begin
                    hold_d = hold_inc;
                end
            end else if (REP_EN) begin
                if (hold_inc == REP_CNT) begin
                    rep_d  = 1'b1;
                    hold_d = '0;
                end else begin
                    hold_d = hold_inc;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q     <= ACTIVE_LOW;
            sync2_q     <= ACTIVE_LOW;
            stab_q      <= '0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            hold_q      <= '0;
            long_done_q <= 1'b0;
            long_q      <= 1'b0;
            rep_q       <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            stab_q      <= stab_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            hold_q      <= hold_d;
            long_done_q <= long_done_d;
            long_q      <= long_d;
            rep_q       <= rep_d;
        end
    end

    always_comb begin
        level         = level_q;
        press         = press_q;
        release_pulse = release_q;
        long_press    = long_q;
        repeat_pulse  = rep_q;
    end

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel front-panel button debouncer: one button_channel per pin, sharing the
// timebase tick.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned N_BUTTONS    = 3,
    parameter bit          ACTIVE_LOW   = 1'b1,
    parameter int unsigned STABLE_TICKS = BTN_STABLE_TICKS,
    parameter int unsigned LONG_TICKS   = BTN_LONG_TICKS,
    parameter int unsigned REPEAT_TICKS = BTN_REPEAT_TICKS
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 tick,
    input  logic [N_BUTTONS-1:0] but_in,
    output logic [N_BUTTONS-1:0] level,
    output logic [N_BUTTONS-1:0] press,
    // release/repeat are SystemVerilog keywords, hence the _pulse suffix
    output logic [N_BUTTONS-1:0] release_pulse,
    output logic [N_BUTTONS-1:0] long_press,
    output logic [N_BUTTONS-1:0] repeat_pulse
);

    if (N_BUTTONS == 0) begin : g_bad_count
        $error("button_conditioner: N_BUTTONS must be at least 1");
    end

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_chan
        button_channel #(
            .ACTIVE_LOW  (ACTIVE_LOW),
            .STABLE_TICKS(STABLE_TICKS),
            .LONG_TICKS  (LONG_TICKS),
            .REPEAT_TICKS(REPEAT_TICKS)
        ) u_chan (
            .clk          (clk),
            .rstn         (rstn),
            .tick         (tick),
            .pin          (but_in[i]),
            .level        (level[i]),
            .press        (press[i]),
            .release_pulse(release_pulse[i]),
            .long_press   (long_press[i]),
            .repeat_pulse (repeat_pulse[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: expected pulses are scheduled per cycle when the
// pins are driven, and both polarities of the DUT are compared against them every cycle.
module tb_button_conditioner;
    import btn_pkg::*;

    localparam int unsigned NB = 3;
    localparam int unsigned ST = 4;
    localparam int unsigned LT = 10;
    localparam int unsigned RT = 3;

    logic          clk  = 1'b0;
    logic          rstn = 1'b1;
    logic          tick = 1'b1;
    logic [NB-1:0] but_in = '1;
    logic [NB-1:0] but_hi;

    logic [NB-1:0] lvl_lo, prs_lo, rel_lo, lng_lo, rpt_lo;
    logic [NB-1:0] lvl_hi, prs_hi, rel_hi, lng_hi, rpt_hi;
    logic [31:0]   outs_lo, outs_hi;

    assign but_hi  = ~but_in;
    assign outs_lo = {17'b0, lvl_lo, prs_lo, rel_lo, lng_lo, rpt_lo};
    assign outs_hi = {17'b0, lvl_hi, prs_hi, rel_hi, lng_hi, rpt_hi};

    button_conditioner #(
        .N_BUTTONS(NB), .ACTIVE_LOW(1'b1), .STABLE_TICKS(ST), .LONG_TICKS(LT), .REPEAT_TICKS(RT)
    ) u_dut (
        .clk(clk), .rstn(rstn), .tick(tick), .but_in(but_in),
        .level(lvl_lo), .press(prs_lo), .release_pulse(rel_lo),
        .long_press(lng_lo), .repeat_pulse(rpt_lo)
    );

    button_conditioner #(
        .N_BUTTONS(NB), .ACTIVE_LOW(1'b0), .STABLE_TICKS(ST), .LONG_TICKS(LT), .REPEAT_TICKS(RT)
    ) u_dut_hi (
        .clk(clk), .rstn(rstn), .tick(tick), .but_in(but_hi),
        .level(lvl_hi), .press(prs_hi), .release_pulse(rel_hi),
        .long_press(lng_hi), .repeat_pulse(rpt_hi)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 0: tick every cycle, 1: tick every 4th cycle, 2: tick held low
    int tick_mode = 0;
    initial forever begin
        @(negedge clk);
        tick = (tick_mode == 0) ? 1'b1 : (tick_mode == 1) ? (cyc % 4 == 0) : 1'b0;
    end

    typedef struct {
        int cyc;
        int ch;
        int kind;  // 0 press, 1 release, 2 long, 3 repeat
    } ev_t;
    ev_t sb[$];

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, got, exp);
        end
    endtask

    // Tick seen by the DUT at clock edge e was driven at the negedge after edge e-1
    function automatic bit tick_at(input int e);
        if (tick_mode == 0) return 1'b1;
        if (tick_mode == 1) return ((e - 1) % 4 == 0);
        return 1'b0;
    endfunction

    // Edge number of the n-th ticked edge at or after edge start
    function automatic int qual(input int start, input int n);
        int k;
        k = 0;
        for (int e = start; e < start + 100000; e++) begin
            if (tick_at(e)) begin
                k++;
                if (k == n) return e;
            end
        end
        return -1;
    endfunction

    task automatic push_ev(input int c, input int ch, input int kind);
        sb.push_back('{cyc: c, ch: ch, kind: kind});
    endtask

    // Pin of channel ch goes active at the negedge after edge k_on and inactive after k_off
    task automatic schedule_hold(input int ch, input int k_on, input int k_off);
        int p, r, e;
        p = qual(k_on + 3, ST);
        r = qual(k_off + 3, ST);
        push_ev(p, ch, 0);
        push_ev(r, ch, 1);
        e = qual(p + 1, LT);
        if (e < r) begin
            push_ev(e, ch, 2);
            for (int j = 1; j < 10000; j++) begin
                e = qual(p + 1, LT + RT * j);
                if (e >= r) break;
                push_ev(e, ch, 3);
            end
        end
    endtask

    task automatic goto_cycle(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
        check_eq("drain_timeout", sb.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    logic [NB-1:0] mon_p, mon_r, mon_l, mon_rp;
    logic [NB-1:0] exp_level = '0;
    logic [31:0]   exp_vec;

    initial forever begin
        @(posedge clk);
        #2;
        mon_p  = '0;
        mon_r  = '0;
        mon_l  = '0;
        mon_rp = '0;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                if (sb[i].cyc == cyc) begin
                    case (sb[i].kind)
                        0:       mon_p[sb[i].ch]  = 1'b1;
                        1:       mon_r[sb[i].ch]  = 1'b1;
                        2:       mon_l[sb[i].ch]  = 1'b1;
                        default: mon_rp[sb[i].ch] = 1'b1;
                    endcase
                end else begin
                    check_eq("sb_stale", sb[i].cyc, cyc);
                end
                sb.delete(i);
            end
        end
        exp_level = (exp_level | mon_p) & ~mon_r;
        if (!rstn) begin
            exp_level = '0;
            mon_p     = '0;
            mon_r     = '0;
            mon_l     = '0;
            mon_rp    = '0;
        end
        exp_vec = {17'b0, exp_level, mon_p, mon_r, mon_l, mon_rp};
        check_eq("outs_active_low", outs_lo, exp_vec);
        check_eq("outs_active_high", outs_hi, exp_vec);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish, %0d events pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int k, k2;
        #1 rstn = 1'b0;
        #1 check_eq("reset_state_lo", outs_lo, 32'd0);
        check_eq("reset_state_hi", outs_hi, 32'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);

        // Clean short press on MODE
        k = cyc;
        but_in[BTN_MODE] = 1'b0;
        schedule_hold(BTN_MODE, k, k + 8);
        goto_cycle(k + 8);
        but_in[BTN_MODE] = 1'b1;
        wait_idle();

        // Bounce on SET, then a settled press with long press and repeats
        for (int i = 0; i < 10; i++) begin
            but_in[BTN_SET] = (i % 2 != 0);
            repeat (2) @(negedge clk);
        end
        k = cyc;
        but_in[BTN_SET] = 1'b0;
        schedule_hold(BTN_SET, k, k + 20);
        goto_cycle(k + 20);
        but_in[BTN_SET] = 1'b1;
        wait_idle();

        // Long hold on ADJ: long press then repeats until release
        k = cyc;
        but_in[BTN_ADJ] = 1'b0;
        schedule_hold(BTN_ADJ, k, k + 46);
        goto_cycle(k + 46);
        but_in[BTN_ADJ] = 1'b1;
        wait_idle();

        // Two channels pressed together, released at different times
        k = cyc;
        but_in[BTN_MODE] = 1'b0;
        but_in[BTN_SET]  = 1'b0;
        schedule_hold(BTN_MODE, k, k + 30);
        schedule_hold(BTN_SET, k, k + 25);
        goto_cycle(k + 25);
        but_in[BTN_SET] = 1'b1;
        goto_cycle(k + 30);
        but_in[BTN_MODE] = 1'b1;
        wait_idle();

        // Tick every 4th cycle
        tick_mode = 1;
        repeat (4) @(negedge clk);
        k = cyc;
        but_in[BTN_MODE] = 1'b0;
        schedule_hold(BTN_MODE, k, k + 70);
        goto_cycle(k + 70);
        but_in[BTN_MODE] = 1'b1;
        wait_idle();

        // Tick held low: a long press must not qualify
        tick_mode = 2;
        repeat (2) @(negedge clk);
        but_in[BTN_ADJ] = 1'b0;
        repeat (30) @(negedge clk);
        but_in[BTN_ADJ] = 1'b1;
        repeat (10) @(negedge clk);
        tick_mode = 0;
        repeat (4) @(negedge clk);
        wait_idle();

        // Reset during the repeat phase with the button still held
        k = cyc;
        but_in[BTN_ADJ] = 1'b0;
        schedule_hold(BTN_ADJ, k, k + 80);
        goto_cycle(k + 25);
        rstn = 1'b0;
        sb.delete();
        #1 check_eq("reset_async_lo", outs_lo, 32'd0);
        check_eq("reset_async_hi", outs_hi, 32'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        k2 = cyc;
        schedule_hold(BTN_ADJ, k2, k + 80);
        goto_cycle(k + 80);
        but_in[BTN_ADJ] = 1'b1;
        wait_idle();

        // Single-cycle glitches on MODE are rejected
        for (int i = 0; i < 6; i++) begin
            but_in[BTN_MODE] = 1'b0;
            @(negedge clk);
            but_in[BTN_MODE] = 1'b1;
            repeat (5) @(negedge clk);
        end
        wait_idle();

        check_eq("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
